signed_fixed_point_divider: RTL and testbench

Iterative signed fixed-point divider; the inverse arithmetic unit of the pipelined fixed-point multiplier.
- Used in the neural-network datapath for normalisation and for averaging over the learning rate / batch size.
- Computes quotient = (dividend << FIXED_POINT_POSITION) / divisor with a start/valid handshake.
- Retires one quotient bit per clock, using restoring division on operand magnitudes.

---
 rtl/fixed_point_pkg.sv | 43 ++++
 rtl/unsigned_restoring_divider_step.sv | 30 +++
 rtl/signed_fixed_point_divider.sv | 160 ++++++++++++++++
 tb/tb_signed_fixed_point_divider.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the neural-network arithmetic units
// (divider and multiplier).
//   FIXED_POINT_LENGTH / FIXED_POINT_POSITION : default word and fraction widths
//   FIXED_POINT_MAX / FIXED_POINT_MIN         : saturation limits at the default width
//   divider_state_t                           : divider FSM states
//   saturate()                                : clamp a wide signed value to a width
package fixed_point_pkg;

  localparam int FIXED_POINT_LENGTH   = 16;
  localparam int FIXED_POINT_POSITION = 10;

  localparam logic [FIXED_POINT_LENGTH-1:0] FIXED_POINT_MAX =
    {1'b0, {(FIXED_POINT_LENGTH-1){1'b1}}};
  localparam logic [FIXED_POINT_LENGTH-1:0] FIXED_POINT_MIN =
    {1'b1, {(FIXED_POINT_LENGTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } divider_state_t;

  localparam int SAT_IN_W = 64;

  // Clamp a wide signed value into the two's complement range of 'width' bits.
  // The result stays sign-extended at SAT_IN_W bits; callers truncate to width.
  function automatic logic signed [SAT_IN_W-1:0] saturate(
    input logic signed [SAT_IN_W-1:0] value,
    input int                         width
  );
    logic signed [SAT_IN_W-1:0] max_v;
    logic signed [SAT_IN_W-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/unsigned_restoring_divider_step.sv
// One combinational step of unsigned restoring division.
//   remainder_i      : partial remainder before this step (WIDTH+1 bits)
//   next_bit_i       : next dividend bit shifted into the remainder
//   divisor_i        : divisor magnitude (WIDTH bits)
//   remainder_o      : partial remainder after the trial subtraction
//   quotient_bit_o   : 1 when the subtraction was kept
module unsigned_restoring_divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   remainder_i,
  input  logic             next_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   remainder_o,
  output logic             quotient_bit_o
);

  // One extra bit of headroom so the shift never loses the top bit, even
  // though a well-formed remainder is always below the divisor.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divisor_ext;

  always_comb begin
    shifted        = {remainder_i, next_bit_i};
    divisor_ext    = (WIDTH+2)'(divisor_i);
    quotient_bit_o = (shifted >= divisor_ext);
    remainder_o    = quotient_bit_o ? (WIDTH+1)'(shifted - divisor_ext)
                                    : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/signed_fixed_point_divider.sv
// Iterative signed fixed-point divider:
//   quotient = (dividend << FIXED_POINT_POSITION) / divisor,
// truncated toward zero and saturated to FIXED_POINT_LENGTH bits. One quotient
// bit retires per clock using restoring division on operand magnitudes.
//
// Ports:
//   clk_in, rst_in          : clock (rising edge), async active-high reset
//   start_in                : request; accepted on an edge where ready_out=1
//   dividend_in, divisor_in : signed operands, sampled on the accept edge
//   ready_out               : a new request can be accepted this cycle
//   valid_out               : one-cycle pulse, quotient_out/div_by_zero_out valid
//   quotient_out            : saturated signed quotient, held until next result
//   div_by_zero_out         : current result came from a zero divisor
//   state_out               : FSM state (divider_state_t encoding) for observation
//
// Handshake: a request is taken on any rising edge with start_in=1 and
// ready_out=1; start_in is ignored otherwise. valid_out is high for exactly one
// cycle per accepted request, and ready_out is already high in that cycle so a
// new request can follow back-to-back.
module signed_fixed_point_divider #(
  parameter int FIXED_POINT_LENGTH   = fixed_point_pkg::FIXED_POINT_LENGTH,
  parameter int FIXED_POINT_POSITION = fixed_point_pkg::FIXED_POINT_POSITION
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic [FIXED_POINT_LENGTH-1:0] dividend_in,
  input  logic [FIXED_POINT_LENGTH-1:0] divisor_in,
  output logic                          ready_out,
  output logic                          valid_out,
  output logic [FIXED_POINT_LENGTH-1:0] quotient_out,
  output logic                          div_by_zero_out,
  output logic [1:0]                    state_out
);

  import fixed_point_pkg::*;

  localparam int N  = FIXED_POINT_LENGTH;
  localparam int P  = FIXED_POINT_POSITION;
  localparam int Q  = N + P;
  localparam int CW = $clog2(Q);
  localparam logic [CW-1:0] LAST_ITER = CW'(Q - 1);
  localparam logic [N-1:0]  SAT_MAX   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SAT_MIN   = {1'b1, {(N-1){1'b0}}};

  divider_state_t state_q;
  logic           ready_q;
  logic           valid_q;
  logic [N-1:0]   quotient_q;
  logic           dbz_q;

  logic           sign_q;
  logic           dividend_neg_q;
  logic           divisor_zero_q;
  logic [N-1:0]   divisor_mag_q;
  logic [Q-1:0]   dividend_sh_q;
  logic [Q-1:0]   quotient_mag_q;
  logic [N:0]     remainder_q;
  logic [CW-1:0]  iter_q;

  logic [N-1:0]   dividend_mag_d;
  logic [N-1:0]   divisor_mag_d;
  logic [N:0]     remainder_d;
  logic           quotient_bit_d;
  logic [N-1:0]   result_d;

  // Magnitude of the most negative value is 2^(N-1), which still fits in N
  // unsigned bits, so plain negation is exact here.
  always_comb begin
    dividend_mag_d = dividend_in[N-1] ? N'(-dividend_in) : dividend_in;
    divisor_mag_d  = divisor_in[N-1]  ? N'(-divisor_in)  : divisor_in;
  end

  unsigned_restoring_divider_step #(
    .WIDTH (N)
  ) u_step (
    .remainder_i    (remainder_q),
    .next_bit_i     (dividend_sh_q[Q-1]),
    .divisor_i      (divisor_mag_q),
    .remainder_o    (remainder_d),
    .quotient_bit_o (quotient_bit_d)
  );

  // Final result: re-apply sign to the magnitude, then clamp. A zero divisor
  // overrides with the limit matching the dividend's sign (zero counts as +).
  always_comb begin
    logic signed [SAT_IN_W-1:0] mag_wide;
    logic signed [SAT_IN_W-1:0] signed_wide;
    mag_wide    = $signed(SAT_IN_W'(quotient_mag_q));
    signed_wide = sign_q ? -mag_wide : mag_wide;
    result_d    = N'(saturate(signed_wide, N));
    if (divisor_zero_q) begin
      result_d = dividend_neg_q ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      ready_q        <= 1'b1;
      valid_q        <= 1'b0;
      quotient_q     <= '0;
      dbz_q          <= 1'b0;
      sign_q         <= 1'b0;
      dividend_neg_q <= 1'b0;
      divisor_zero_q <= 1'b0;
      divisor_mag_q  <= '0;
      dividend_sh_q  <= '0;
      quotient_mag_q <= '0;
      remainder_q    <= '0;
      iter_q         <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (start_in) begin
            sign_q         <= dividend_in[N-1] ^ divisor_in[N-1];
            dividend_neg_q <= dividend_in[N-1];
            divisor_zero_q <= (divisor_in == '0);
            divisor_mag_q  <= divisor_mag_d;
            dividend_sh_q  <= {dividend_mag_d, {P{1'b0}}};
            quotient_mag_q <= '0;
            remainder_q    <= '0;
            iter_q         <= '0;
            ready_q        <= 1'b0;
            state_q        <= DIVIDE;
          end
        end
        DIVIDE: begin
          dividend_sh_q  <= {dividend_sh_q[Q-2:0], 1'b0};
          remainder_q    <= remainder_d;
          quotient_mag_q <= {quotient_mag_q[Q-2:0], quotient_bit_d};
          iter_q         <= iter_q + CW'(1);
          if (iter_q == LAST_ITER) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          quotient_q <= result_d;
          dbz_q      <= divisor_zero_q;
          valid_q    <= 1'b1;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_out       = ready_q;
  assign valid_out       = valid_q;
  assign quotient_out    = quotient_q;
  assign div_by_zero_out = dbz_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_signed_fixed_point_divider.sv
// Self-checking bench for signed_fixed_point_divider (defaults N=16, P=10).
// Directed table of operands with hand-computed quotients, hand-written
// sequences for reset abort, hold and back-to-back handshakes, plus random
// operands checked against a truncate-then-saturate reference.
module tb_signed_fixed_point_divider;

  localparam int N       = 16;
  localparam int LATENCY = 27;   // edges from accept to the valid_out edge
  localparam int PERIOD  = 28;   // edges between back-to-back valid pulses

  logic         clk_in;
  logic         rst_in;
  logic         start_in;
  logic [N-1:0] dividend_in;
  logic [N-1:0] divisor_in;
  logic         ready_out;
  logic         valid_out;
  logic [N-1:0] quotient_out;
  logic         div_by_zero_out;
  logic [1:0]   state_out;

  signed_fixed_point_divider dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .dividend_in     (dividend_in),
    .divisor_in      (divisor_in),
    .ready_out       (ready_out),
    .valid_out       (valid_out),
    .quotient_out    (quotient_out),
    .div_by_zero_out (div_by_zero_out),
    .state_out       (state_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard ----------------
  int checks_total  = 0;
  int checks_passed = 0;
  logic [N:0] exp_q[$];   // {div_by_zero, quotient}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic         z;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q, input logic z);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.q = q; v.z = z;
    vecs.push_back(v);
  endtask

  // Reference: truncate toward zero on magnitudes, then saturate.
  function automatic logic [N:0] model(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    longint ma, mb, mq, sq;
    logic [N-1:0] r;
    if (b == 0) begin
      r = (a < 0) ? 16'h8000 : 16'h7FFF;
      return {1'b1, r};
    end
    ma = (a < 0) ? -longint'(a) : longint'(a);
    mb = (b < 0) ? -longint'(b) : longint'(b);
    mq = (ma * 1024) / mb;
    sq = ((a < 0) != (b < 0)) ? -mq : mq;
    if (sq > 32767)  sq = 32767;
    if (sq < -32768) sq = -32768;
    r = sq[N-1:0];
    return {1'b0, r};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] q, output logic z, output int lat);
    int guard;
    guard = 0;
    @(negedge clk_in);
    while (!ready_out && guard < 100) begin
      @(negedge clk_in);
      guard++;
    end
    start_in    = 1'b1;
    dividend_in = a;
    divisor_in  = b;
    @(posedge clk_in);
    #1;
    start_in    = 1'b0;
    dividend_in = N'($urandom);
    divisor_in  = N'($urandom);
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
    end while (!valid_out && lat < 100);
    q = quotient_out;
    z = div_by_zero_out;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [N-1:0] q;
    logic         z;
    int           lat;
    logic [N:0]   exp;
    int           seen;
    int           gap;
    logic [N-1:0] ra, rb;

    rst_in      = 1'b1;
    start_in    = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    #1;
    check("reset_ready", ready_out, 1);
    check("reset_valid", valid_out, 0);
    check("reset_quotient", quotient_out, 0);
    check("reset_dbz", div_by_zero_out, 0);
    check("reset_state", state_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    add_vec("3.0/2.0",        16'd3072,    16'd2048,    16'd1536,    1'b0);
    add_vec("-0.25",          16'(-1024),  16'd4096,    16'(-256),   1'b0);
    add_vec("trunc_pp",       16'd1024,    16'd3072,    16'd341,     1'b0);
    add_vec("trunc_np",       16'(-1024),  16'd3072,    16'(-341),   1'b0);
    add_vec("trunc_pn",       16'd1024,    16'(-3072),  16'(-341),   1'b0);
    add_vec("trunc_nn",       16'(-1024),  16'(-3072),  16'd341,     1'b0);
    add_vec("sat_pos",        16'd16384,   16'd1,       16'h7FFF,    1'b0);
    add_vec("sat_neg",        16'(-16384), 16'd1,       16'h8000,    1'b0);
    add_vec("min_exact",      16'h8000,    16'd1024,    16'h8000,    1'b0);
    add_vec("min_neg_div",    16'h8000,    16'(-1024),  16'h7FFF,    1'b0);
    add_vec("dbz_pos",        16'd5120,    16'd0,       16'h7FFF,    1'b1);
    add_vec("dbz_neg",        16'(-5120),  16'd0,       16'h8000,    1'b1);
    add_vec("dbz_zero",       16'd0,       16'd0,       16'h7FFF,    1'b1);

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].z, vecs[i].q});
      run_op(vecs[i].a, vecs[i].b, q, z, lat);
      exp = exp_q.pop_front();
      check({vecs[i].name, "_result"}, {z, q}, exp);
      check({vecs[i].name, "_latency"}, lat, LATENCY);
    end

    // Result holds while idle; valid_out is a single-cycle pulse.
    repeat (5) @(posedge clk_in);
    #1;
    check("hold_quotient", quotient_out, 16'h7FFF);
    check("hold_dbz", div_by_zero_out, 1);
    check("hold_valid_low", valid_out, 0);

    // Reset in the middle of a divide aborts it.
    @(negedge clk_in);
    start_in = 1'b1; dividend_in = 16'd3072; divisor_in = 16'd2048;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("abort_ready", ready_out, 1);
    check("abort_valid", valid_out, 0);
    check("abort_quotient", quotient_out, 0);
    check("abort_dbz", div_by_zero_out, 0);
    check("abort_state", state_out, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk_in);
      #1;
      if (valid_out) seen++;
    end
    check("abort_no_valid", seen, 0);

    // start_in held high through the divide with changing operands is
    // ignored; it is then accepted in the valid_out cycle.
    @(negedge clk_in);
    start_in = 1'b1; dividend_in = 16'd1024; divisor_in = 16'd3072;
    @(posedge clk_in);
    #1;
    dividend_in = 16'd5120; divisor_in = 16'd0;
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
      check("held_start_ignored", ready_out | valid_out, (lat >= LATENCY) ? 1 : 0);
    end while (!valid_out && lat < 100);
    check("b2b_first_latency", lat, LATENCY);
    check("b2b_first_result", {div_by_zero_out, quotient_out}, {1'b0, 16'd341});
    check("b2b_ready_in_valid", ready_out, 1);
    dividend_in = 16'(-1024); divisor_in = 16'd4096;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    check("b2b_accepted", ready_out, 0);
    check("b2b_pulse_one_cycle", valid_out, 0);
    check("b2b_hold_between", quotient_out, 16'd341);
    gap = 1;
    do begin
      @(posedge clk_in);
      #1;
      gap++;
    end while (!valid_out && gap < 100);
    check("b2b_period", gap, PERIOD);
    check("b2b_second_result", {div_by_zero_out, quotient_out}, {1'b0, 16'(-256)});

    // Random operands against the reference.
    for (int i = 0; i < 8; i++) begin
      ra = N'($urandom_range(0, 65535));
      if (i % 2 == 0) begin
        rb = N'($urandom_range(1, 2047));
        if ($urandom_range(0, 1) == 1) rb = N'(-rb);
      end else begin
        rb = N'($urandom_range(0, 65535));
      end
      exp_q.push_back(model(ra, rb));
      run_op(ra, rb, q, z, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_%0h_%0h", i, ra, rb), {z, q}, exp);
      check($sformatf("rand%0d_latency", i), lat, LATENCY);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
